// File: rtl/ram_bank_arbiter_pkg.sv
// Shared encodings and geometry for the two-port byte-sliced RAM bank arbiter.
package ram_bank_arbiter_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam int BANK_AW = 10;
  localparam int NBANK   = 4;
endpackage

// File: rtl/ram_bank_arbiter_lane_steer.sv
// Byte-lane steering for stores and lane select plus extension for loads.
module mem_lane_steer
  import ram_bank_arbiter_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic             uns,
  input  logic [31:0]      wdata,
  input  logic [31:0]      bank_q,
  output logic [NBANK-1:0] sel,
  output logic [31:0]      bank_d,
  output logic [31:0]      ldata,
  output logic             misaligned
);
  logic [7:0]  lb;
  logic [15:0] lh;

  assign lb = bank_q[{addr_lo, 3'b000} +: 8];
  assign lh = addr_lo[1] ? bank_q[31:16] : bank_q[15:0];

  always_comb begin
    sel        = '0;
    bank_d     = wdata;
    ldata      = '0;
    misaligned = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        sel    = 4'b0001 << addr_lo;
        bank_d = {4{wdata[7:0]}};
        ldata  = uns ? {24'h0, lb} : {{24{lb[7]}}, lb};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        sel        = 4'b0011 << {addr_lo[1], 1'b0};
        bank_d     = {2{wdata[15:0]}};
        ldata      = uns ? {16'h0, lh} : {{16{lh[15]}}, lh};
      end
      SZ_WORD: begin
        misaligned = |addr_lo;
        sel        = 4'b1111;
        ldata      = bank_q;
      end
      default: misaligned = 1'b1;
    endcase
  end
endmodule

// File: rtl/ram_bank_arbiter.sv
// Round-robin arbiter of two requesters onto a 4-bank byte-sliced RAM, one response buffer per port.
module ram_bank_arbiter
  import ram_bank_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter bit RR_INIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [1:0]         req0_size,
  input  logic               req0_unsigned,
  input  logic [31:0]        req0_wdata,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [31:0]        rsp0_rdata,
  output logic               rsp0_err,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [1:0]         req1_size,
  input  logic               req1_unsigned,
  input  logic [31:0]        req1_wdata,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [31:0]        rsp1_rdata,
  output logic               rsp1_err,
  output logic [BANK_AW-1:0] bank_addr,
  output logic [31:0]        bank_d,
  output logic               bank_we,
  output logic [NBANK-1:0]   bank_sel,
  input  logic [31:0]        bank_q
);
  logic              last_grant;
  logic              elig0, elig1, grant0, grant1, any_grant;
  logic              win_we, win_uns;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        win_size;
  logic [31:0]       win_wdata;
  logic [NBANK-1:0]  st_sel;
  logic [31:0]       st_d, st_ldata, rsp_data;
  logic              st_mis;

  // A port with a full buffer is eligible only if that buffer drains this cycle.
  always_comb begin
    elig0     = req0_valid & (~rsp0_valid | rsp0_ready);
    elig1     = req1_valid & (~rsp1_valid | rsp1_ready);
    grant0    = rst_n & elig0 & (~elig1 | last_grant);
    grant1    = rst_n & elig1 & (~elig0 | ~last_grant);
    any_grant = grant0 | grant1;
    win_we    = grant1 ? req1_we       : req0_we;
    win_uns   = grant1 ? req1_unsigned : req0_unsigned;
    win_addr  = grant1 ? req1_addr     : req0_addr;
    win_size  = grant1 ? req1_size     : req0_size;
    win_wdata = grant1 ? req1_wdata    : req0_wdata;
  end

  mem_lane_steer u_steer (
    .size       (win_size),
    .addr_lo    (win_addr[1:0]),
    .uns        (win_uns),
    .wdata      (win_wdata),
    .bank_q     (bank_q),
    .sel        (st_sel),
    .bank_d     (st_d),
    .ldata      (st_ldata),
    .misaligned (st_mis)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign bank_addr  = win_addr[ADDR_W-1:2];
  assign bank_d     = st_d;
  assign bank_we    = any_grant & win_we & ~st_mis;
  assign bank_sel   = (any_grant & ~st_mis) ? st_sel : '0;
  assign rsp_data   = (win_we | st_mis) ? '0 : st_ldata;

  // Accept edge: capture the response; a drain and a refill on the same edge keep valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= RR_INIT;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      if (grant0) last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;
      if (grant0) begin
        rsp0_valid <= 1'b1;
        rsp0_rdata <= rsp_data;
        rsp0_err   <= st_mis;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid <= 1'b1;
        rsp1_rdata <= rsp_data;
        rsp1_err   <= st_mis;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ram_bank_arbiter.md
Name: ram_bank_arbiter

Overview:
- Arbitrates two requesters (port 0: CPU data port; port 1: loader/debug port) onto one 4-bank byte-sliced data memory.
- Each bank is 1K x 8 with an asynchronous read, a write on the clk rising edge, and a per-bank select.
- Steers byte lanes for byte/half/word stores and sign- or zero-extends loads.
- Buffers one response per requester, with a valid/ready handshake on both the request and response sides.

Parameters:
ADDR_W, 12, byte-address width; bank index is addr[ADDR_W-1:2], 10 bits.
RR_INIT, 1, reset value of last_grant; 1 means port 0 wins the first contention.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
reqN_valid  in  1  request valid (N = 0, 1)
reqN_ready  out  1  request accepted this cycle when valid&ready
reqN_we  in  1  1 = store, 0 = load
reqN_addr  in  ADDR_W  byte address
reqN_size  in  2  00 byte, 01 half, 10 word, 11 illegal
reqN_unsigned  in  1  load zero-extend when 1
reqN_wdata  in  32  store data, right-aligned
rspN_valid  out  1  response buffered
rspN_ready  in  1  requester consumes response
rspN_rdata  out  32  load result (0 for stores/errors)
rspN_err  out  1  misaligned or illegal size
bank_addr  out  10  shared bank address
bank_d  out  32  lane k feeds bank k, bits [8k+7:8k]
bank_we  out  1  write enable
bank_sel  out  4  per-bank select; a bank writes only when we&sel[k]
bank_q  in  32  combinational bank read data, lane k from bank k

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - rspN_valid=0, rspN_err=0, rspN_rdata=0, last_grant=RR_INIT.
  - bank_we and bank_sel are forced 0 combinationally while rst_n=0, so no write occurs during a reset cycle.
  - An in-flight buffered response is discarded.
- Eligibility: eligN = reqN_valid & (!rspN_valid | rspN_ready), so the buffer can drain and refill in the same cycle.
- Grant:
  - Only one eligible requester: it wins.
  - Both eligible: the port other than last_grant wins.
  - last_grant updates to the winner on every accepted request.
  - reqN_ready = grantN, combinational; it never asserts for an ineligible port.
- Bank drive (grant cycle only, combinational from the winner):
  - bank_addr = addr[11:2].
  - byte: sel = 0001<<addr[1:0], bank_d = {4{wdata[7:0]}}.
  - half: sel = 0011<<{addr[1],1'b0}, bank_d = {2{wdata[15:0]}}.
  - word: sel = 1111, bank_d = wdata.
  - bank_we = winner.we & !misaligned.
  - No grant or misaligned access: bank_we=0 and sel=0. bank_sel is also asserted for loads.
- Misaligned access is any of: half with addr[0]=1; word with addr[1:0]!=0; size=11.
  - Such a request is still accepted, with no bank write.
  - Response has err=1 and rdata=0.
- Load data:
  - Lane select by addr[1:0] (byte) or addr[1] (half).
  - Extend per the unsigned flag; word loads pass bank_q unchanged.
  - Captured into rspN_rdata at the accept edge. Stores return rdata=0, err=0.
- Latency:
  - Request accepted at edge T: the write commits at T, and rspN_valid=1 from T until the edge where rspN_valid & rspN_ready.
  - Response is held stable while not consumed.
  - Zero-wait back-to-back: with rspN_ready held high, port N can issue every cycle.
- Backpressure: a port with a pending unconsumed response is not granted, and the other port proceeds freely.
- Read-after-write: a load of the same word one cycle after a store returns the stored data, because bank_q is asynchronous.
- Simultaneous drain and accept on one port: the new response overwrites the buffer at the same edge; rsp_valid stays 1.

Decomposition:
- Shared package: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL, BANK_AW=10, NBANK=4.
- One sub-module, mem_lane_steer (combinational): given size, addr[1:0], unsigned, wdata and bank_q, it produces sel, bank_d, load data and misaligned.
- The arbiter, per-port response buffers and last_grant register stay in the top.

Test Plan:
- Reset with req0 valid store held: no bank write during reset; rsp0_valid=0. After release, port 0 is granted first (RR_INIT=1).
- Port 0 SW addr 0x010 wdata 0xA1B2C3D4, then LB addr 0x013 (signed) -> rdata 0xFFFFFFA1. LBU -> 0x000000A1. LH addr 0x012 -> 0xFFFFA1B2.
- Both ports valid every cycle with rsp_ready=1: grants alternate 0,1,0,1; each rsp_valid pulses in the cycle after its grant.
- rsp1_ready=0 with a response pending, both requesting: port 0 granted every cycle, port 1 stalls. rsp1_ready=1 -> port 1 granted the same cycle.
- SH addr 0x021 and SW addr 0x022: accepted, bank_we=0, err=1, rdata=0. A following LW 0x020 is unchanged from its prior contents.
- SB addr 0x031 wdata 0x5A: bank_sel=0010, bank_d=0x5A5A5A5A. LW 0x030 then shows only byte 1 changed.
